// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, word address to instruction memory, and a
// 2-entry {pc, instr} queue presented to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10,
    parameter int          FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic               misalign_err
);

    logic [31:0] pc_reg;
    logic        head_reg;
    logic        tail_reg;
    logic [1:0]  count_reg;
    logic        misalign_reg;
    logic [31:0] q_pc_reg    [FQ_DEPTH];
    logic [31:0] q_instr_reg [FQ_DEPTH];

    logic pop;
    logic push;

    assign pop  = if_valid & if_ready;
    // A full queue can still accept the current word when the head leaves this cycle.
    assign push = !redirect_valid && ((count_reg != 2'(FQ_DEPTH)) || pop);

    assign imem_addr    = pc_reg[IMEM_AW+1:2];
    assign if_valid     = (count_reg != 2'd0);
    assign if_instr     = if_valid ? q_instr_reg[head_reg] : 32'h0;
    assign if_pc        = if_valid ? q_pc_reg[head_reg] : 32'h0;
    assign misalign_err = misalign_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg       <= RESET_PC;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            count_reg    <= 2'd0;
            misalign_reg <= 1'b0;
        end else if (redirect_valid) begin
            // Any pop this cycle still completes; everything left in the queue is dropped.
            pc_reg    <= {redirect_target[31:2], 2'b00};
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_reg <= 1'b1;
            end
        end else begin
            if (push) begin
                tail_reg <= ~tail_reg;
                pc_reg   <= pc_reg + 32'd4;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_pc_reg[gi]    <= 32'h0;
                    q_instr_reg[gi] <= 32'h0;
                end else if (push && (tail_reg == 1'(gi))) begin
                    q_pc_reg[gi]    <= pc_reg;
                    q_instr_reg[gi] <= imem_instr;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue of expected {pc, instr} accepted by
// decode, checked by a negedge monitor, plus per-cycle checks of address and status.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(10), .FQ_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Memory contents: every word is distinct and encodes its own address.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {6'h2D, a, 16'hBEEF ^ {6'h0, a}};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] p);
        exp_q.push_back(p);
    endtask

    // Monitor: every completed handshake must match the next expected entry.
    always @(negedge clk) begin
        if (reset && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL accept_unexpected: got pc %h expected none", if_pc);
            end else begin
                logic [31:0] p;
                p = exp_q.pop_front();
                chk("accept_pc", if_pc, p);
                chk("accept_instr", if_instr, mem_word(p[11:2]));
                $display("accept pc=%h instr=%h", if_pc, if_instr);
            end
        end
    end

    initial begin
        reset           = 1'b0;
        if_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (3) tick();
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_addr", {22'h0, imem_addr}, 32'h0);
        chk("rst_err", {31'h0, misalign_err}, 32'h0);

        // Startup and backpressure
        foreach (exp_q[i]) exp_q.delete(i);
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        expect_pc(32'hC); expect_pc(32'h10); expect_pc(32'h14);
        reset = 1'b1;
        chk("start_addr0", {22'h0, imem_addr}, 32'h0);
        chk("start_valid0", {31'h0, if_valid}, 32'h0);
        tick();
        chk("start_valid1", {31'h0, if_valid}, 32'h1);
        chk("start_pc1", if_pc, 32'h0);
        chk("start_addr1", {22'h0, imem_addr}, 32'h1);
        tick();
        chk("start_pc2", if_pc, 32'h4);
        chk("start_addr2", {22'h0, imem_addr}, 32'h2);
        tick();
        chk("start_pc3", if_pc, 32'h8);
        chk("start_addr3", {22'h0, imem_addr}, 32'h3);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_addr_frozen", {22'h0, imem_addr}, 32'h4);
            chk("bp_pc_held", if_pc, 32'h8);
        end
        tick();
        if_ready = 1'b1;
        chk("bp_release_addr", {22'h0, imem_addr}, 32'h4);
        tick();
        chk("bp_resume_pc", if_pc, 32'hC);
        chk("bp_resume_addr", {22'h0, imem_addr}, 32'h5);
        repeat (3) tick();

        // Redirect with a full queue
        if_ready = 1'b0;
        chk("full_head", if_pc, 32'h18);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        chk("redir_valid_low", {31'h0, if_valid}, 32'h0);
        chk("redir_addr", {22'h0, imem_addr}, 32'h40);
        chk("redir_err_clear", {31'h0, misalign_err}, 32'h0);
        expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
        expect_pc(32'h204); expect_pc(32'h208);
        tick();
        chk("redir_target_pc", if_pc, 32'h100);

        // Redirect with a pop in the same cycle, misaligned target
        tick();
        tick();
        chk("pop_redir_head", if_pc, 32'h108);
        chk("pre_misalign_err", {31'h0, misalign_err}, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h206;
        tick();
        redirect_valid = 1'b0;
        chk("mis_valid_low", {31'h0, if_valid}, 32'h0);
        chk("mis_err_set", {31'h0, misalign_err}, 32'h1);
        chk("mis_addr", {22'h0, imem_addr}, 32'h81);
        tick();
        chk("mis_pc", if_pc, 32'h204);

        // Wrap of the word address and of the 32-bit PC
        expect_pc(32'hFFC); expect_pc(32'h1000);
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        tick();
        chk("wrap_pre_pc", if_pc, 32'h208);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr_1023", {22'h0, imem_addr}, 32'h3FF);
        chk("err_sticky", {31'h0, misalign_err}, 32'h1);
        tick();
        chk("wrap_pc_ffc", if_pc, 32'hFFC);
        chk("wrap_addr_0", {22'h0, imem_addr}, 32'h0);
        tick();
        chk("wrap_pc_1000", if_pc, 32'h1000);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("pcwrap_addr", {22'h0, imem_addr}, 32'h3FF);
        tick();
        chk("pcwrap_top", if_pc, 32'hFFFF_FFFC);
        chk("pcwrap_addr0", {22'h0, imem_addr}, 32'h0);
        tick();
        chk("pcwrap_zero", if_pc, 32'h0);
        chk("err_still_set", {31'h0, misalign_err}, 32'h1);

        // Reset mid-stream, then restart as from power-up
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'h0, if_valid}, 32'h0);
        chk("midrst_pc", if_pc, 32'h0);
        chk("midrst_err", {31'h0, misalign_err}, 32'h0);
        chk("midrst_addr", {22'h0, imem_addr}, 32'h0);
        repeat (3) tick();
        expect_pc(32'h0); expect_pc(32'h4);
        reset = 1'b1;
        chk("restart_addr0", {22'h0, imem_addr}, 32'h0);
        tick();
        chk("restart_pc0", if_pc, 32'h0);
        chk("restart_addr1", {22'h0, imem_addr}, 32'h1);
        tick();
        chk("restart_pc4", if_pc, 32'h4);
        tick();
        if_ready = 1'b0;
        chk("restart_addr3", {22'h0, imem_addr}, 32'h3);
        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
